// File: rtl/alu_cond_wb_stage_if.sv
// Beat-in / write-back-out handshake bundle for alu_cond_wb_stage.
// The master drives beats in and accepts write-backs.
// The slave is the stage itself.
interface alu_cond_wb_stage_if #(
    parameter int DW = 32,
    parameter int RW = 4
);
    // Upstream beat from the ALU
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_result;
    logic [3:0]    in_flags;
    logic [1:0]    in_flagw;
    logic [3:0]    in_cond;
    logic          in_regwrite;
    logic [RW-1:0] in_rd;

    // Downstream write-back request
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [RW-1:0] out_rd;
    logic          out_we;

    modport master (
        output in_valid, in_result, in_flags, in_flagw, in_cond, in_regwrite, in_rd,
        output out_ready,
        input  in_ready,
        input  out_valid, out_data, out_rd, out_we
    );

    modport slave (
        input  in_valid, in_result, in_flags, in_flagw, in_cond, in_regwrite, in_rd,
        input  out_ready,
        output in_ready,
        output out_valid, out_data, out_rd, out_we
    );
endinterface

// File: rtl/alu_cond_wb_stage.sv
// Condition-evaluate and write-back stage after the ALU.
// It checks the beat's condition code against the architectural NZCV register.
// It updates NZCV under the flag-write mask when the condition passes.
// It queues {result, rd, we} in a 2-entry FIFO.
// An entry whose condition failed is still queued with we=0, so beat order is kept.
module alu_cond_wb_stage #(
    parameter int DW    = 32,
    parameter int RW    = 4,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_cond_wb_stage_if.slave   bus,
    input  logic                 flush,
    output logic [3:0]           flags_q,
    output logic                 cond_pass
);

    // Full threshold. The pointers are 1 bit wide, so only DEPTH=2 is meaningful.
    localparam logic [1:0] FULL = 2'(DEPTH);

    logic [1:0]    count_q, count_d;
    logic          wptr_q, wptr_d;
    logic          rptr_q, rptr_d;
    logic [3:0]    flags_d;

    logic [DW-1:0] data_q [2];
    logic [RW-1:0] rd_q   [2];
    logic          we_q   [2];

    logic          push;
    logic          pop;

    // Condition code against NZCV. 1111 is treated as always.
    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        n = nzcv[3];
        z = nzcv[2];
        c = nzcv[1];
        v = nzcv[0];
        case (cond)
            4'b0000: cond_eval = z;
            4'b0001: cond_eval = ~z;
            4'b0010: cond_eval = c;
            4'b0011: cond_eval = ~c;
            4'b0100: cond_eval = n;
            4'b0101: cond_eval = ~n;
            4'b0110: cond_eval = v;
            4'b0111: cond_eval = ~v;
            4'b1000: cond_eval = c & ~z;
            4'b1001: cond_eval = ~c | z;
            4'b1010: cond_eval = (n == v);
            4'b1011: cond_eval = (n != v);
            4'b1100: cond_eval = ~z & (n == v);
            4'b1101: cond_eval = z | (n != v);
            default: cond_eval = 1'b1;
        endcase
    endfunction

    // Handshakes and head-slot outputs.
    // in_ready depends only on occupancy and flush, never on in_valid.
    always_comb begin
        cond_pass     = cond_eval(bus.in_cond, flags_q);
        bus.in_ready  = (count_q < FULL) & ~flush;
        bus.out_valid = (count_q != 2'd0);
        bus.out_data  = data_q[rptr_q];
        bus.out_rd    = rd_q[rptr_q];
        bus.out_we    = we_q[rptr_q];
        push          = bus.in_valid & bus.in_ready;
        pop           = bus.out_valid & bus.out_ready & ~flush;
    end

    // Next-state logic for occupancy, pointers and NZCV.
    // Flush wins over pop; a push cannot coincide with a flush.
    always_comb begin
        count_d = count_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        flags_d = flags_q;

        if (flush) begin
            count_d = 2'd0;
            wptr_d  = 1'b0;
            rptr_d  = 1'b0;
        end else begin
            if (push) wptr_d = ~wptr_q;
            if (pop)  rptr_d = ~rptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end

        if (push && cond_pass) begin
            if (bus.in_flagw[1]) flags_d[3:2] = bus.in_flags[3:2];
            if (bus.in_flagw[0]) flags_d[1:0] = bus.in_flags[1:0];
        end
    end

    // Control and flag state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            flags_q <= 4'b0000;
        end else begin
            count_q <= count_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            flags_q <= flags_d;
        end
    end

    // FIFO storage. It is cleared on reset so that the idle head reads as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                rd_q[i]   <= '0;
                we_q[i]   <= 1'b0;
            end
        end else if (push) begin
            data_q[wptr_q] <= bus.in_result;
            rd_q[wptr_q]   <= bus.in_rd;
            we_q[wptr_q]   <= bus.in_regwrite & cond_pass;
        end
    end

endmodule

// File: tb/tb_alu_cond_wb_stage.sv
// Directed plus random bench for alu_cond_wb_stage.
// A queue-based model tracks the FIFO contents and the NZCV register.
module tb_alu_cond_wb_stage;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic [3:0] flags_q;
    logic cond_pass;

    always #5 clk = ~clk;

    alu_cond_wb_stage_if #(.DW(32), .RW(4)) bus ();

    alu_cond_wb_stage #(.DW(32), .RW(4), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .flush     (flush),
        .flags_q   (flags_q),
        .cond_pass (cond_pass)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  rd;
        logic        we;
    } ent_t;

    ent_t       mq[$];
    logic [3:0] mflags = 4'b0000;
    int         n_vec  = 0;
    int         n_fail = 0;

    // Base condition from cond[3:1]; cond[0] inverts it, except for the always pair.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic base;
        case (c[3:1])
            3'd0: base = f[2];
            3'd1: base = f[1];
            3'd2: base = f[3];
            3'd3: base = f[0];
            3'd4: base = f[1] && !f[2];
            3'd5: base = (f[3] == f[0]);
            3'd6: base = !f[2] && (f[3] == f[0]);
            default: return 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] res, input logic [3:0] fl,
                         input logic [1:0] fw, input logic [3:0] cd, input logic rw,
                         input logic [3:0] rd);
        bus.in_valid    = v;
        bus.in_result   = res;
        bus.in_flags    = fl;
        bus.in_flagw    = fw;
        bus.in_cond     = cd;
        bus.in_regwrite = rw;
        bus.in_rd       = rd;
    endtask

    // One clock: check the DUT against the model, advance the model, then clock the DUT.
    // Inputs must already be driven; the task returns at the next falling edge.
    task automatic step();
        logic exp_ready, exp_pass, do_push, do_pop;
        ent_t e;
        #1;
        exp_ready = (mq.size() < 2) && !flush;
        exp_pass  = ref_cond(bus.in_cond, mflags);
        chk("in_ready",  64'(bus.in_ready),  64'(exp_ready));
        chk("cond_pass", 64'(cond_pass),     64'(exp_pass));
        chk("out_valid", 64'(bus.out_valid), 64'(mq.size() != 0));
        chk("flags_q",   64'(flags_q),       64'(mflags));
        if (mq.size() != 0) begin
            chk("out_data", 64'(bus.out_data), 64'(mq[0].d));
            chk("out_rd",   64'(bus.out_rd),   64'(mq[0].rd));
            chk("out_we",   64'(bus.out_we),   64'(mq[0].we));
        end
        do_push = bus.in_valid && exp_ready;
        do_pop  = (mq.size() != 0) && bus.out_ready && !flush;
        if (flush) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                e.d  = bus.in_result;
                e.rd = bus.in_rd;
                e.we = bus.in_regwrite && exp_pass;
                mq.push_back(e);
            end
        end
        if (do_push && exp_pass) begin
            if (bus.in_flagw[1]) mflags[3:2] = bus.in_flags[3:2];
            if (bus.in_flagw[0]) mflags[1:0] = bus.in_flags[1:0];
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] saved_flags;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 2'b00, 4'h0, 1'b0, 4'h0);

        // Reset held low, with random inputs applied.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'($urandom), $urandom, 4'($urandom), 2'($urandom), 4'($urandom),
                  1'($urandom), 4'($urandom));
            bus.out_ready = 1'($urandom);
            #1;
            chk("rst_flags",     64'(flags_q),       64'h0);
            chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
            chk("rst_in_ready",  64'(bus.in_ready),  64'h1);
            chk("rst_out_data",  64'(bus.out_data),  64'h0);
            chk("rst_out_rd",    64'(bus.out_rd),    64'h0);
            chk("rst_out_we",    64'(bus.out_we),    64'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // First beat after reset
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h5, 4'b0100, 2'b11, 4'b1110, 1'b1, 4'd3);
        step();
        chk("first_data",  64'(bus.out_data), 64'h5);
        chk("first_rd",    64'(bus.out_rd),   64'd3);
        chk("first_we",    64'(bus.out_we),   64'h1);
        chk("first_flags", 64'(flags_q),      64'b0100);
        bus.out_ready = 1'b1;
        drive(1'b0, 32'h0, 4'h0, 2'b00, 4'h0, 1'b0, 4'h0);
        step();

        // Condition gating: NE fails with Z set, then EQ passes
        drive(1'b1, 32'h11, 4'b1000, 2'b11, 4'b0001, 1'b1, 4'd1);
        step();
        chk("ne_we",    64'(bus.out_we), 64'h0);
        chk("ne_flags", 64'(flags_q),    64'b0100);
        drive(1'b1, 32'h22, 4'b0000, 2'b00, 4'b0000, 1'b1, 4'd2);
        step();
        chk("eq_we", 64'(bus.out_we), 64'h1);
        drive(1'b0, 32'h0, 4'h0, 2'b00, 4'h0, 1'b0, 4'h0);
        step();

        // Partial flag writes
        drive(1'b1, 32'h30, 4'b0000, 2'b11, 4'b1110, 1'b0, 4'd0);
        step();
        drive(1'b1, 32'h31, 4'b1111, 2'b01, 4'b1110, 1'b1, 4'd1);
        step();
        chk("flagw_cv", 64'(flags_q), 64'b0011);
        drive(1'b1, 32'h32, 4'b1100, 2'b10, 4'b1110, 1'b1, 4'd2);
        step();
        chk("flagw_nz", 64'(flags_q), 64'b1111);
        drive(1'b0, 32'h0, 4'h0, 2'b00, 4'h0, 1'b0, 4'h0);
        step();

        // Backpressure: A and B fill the FIFO, and C is held until a slot frees
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hA0, 4'h0, 2'b00, 4'b1110, 1'b1, 4'd10);
        step();
        drive(1'b1, 32'hB0, 4'h0, 2'b00, 4'b1110, 1'b1, 4'd11);
        step();
        drive(1'b1, 32'hC0, 4'h0, 2'b00, 4'b1110, 1'b1, 4'd12);
        #1;
        chk("full_in_ready", 64'(bus.in_ready), 64'h0);
        chk("full_head_A",   64'(bus.out_data), 64'hA0);
        step();
        bus.out_ready = 1'b1;
        step();
        chk("head_B", 64'(bus.out_data), 64'hB0);
        step();
        chk("head_C", 64'(bus.out_data), 64'hC0);
        drive(1'b0, 32'h0, 4'h0, 2'b00, 4'h0, 1'b0, 4'h0);
        step();
        chk("drained", 64'(bus.out_valid), 64'h0);

        // Continuous stream at occupancy 1
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h100, 4'h0, 2'b00, 4'b1110, 1'b1, 4'd0);
        step();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 32'h100 + 32'(i), 4'h0, 2'b00, 4'b1110, 1'b1, 4'(i));
            step();
            chk("stream_head", 64'(bus.out_data), 64'(32'h100 + 32'(i)));
        end
        drive(1'b0, 32'h0, 4'h0, 2'b00, 4'h0, 1'b0, 4'h0);
        step();

        // Flush with a full FIFO and a valid beat pending
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hD0, 4'b1010, 2'b11, 4'b1110, 1'b1, 4'd4);
        step();
        drive(1'b1, 32'hD1, 4'b0101, 2'b11, 4'b1110, 1'b1, 4'd5);
        step();
        saved_flags = mflags;
        drive(1'b1, 32'hD2, 4'b1111, 2'b11, 4'b1110, 1'b1, 4'd6);
        bus.out_ready = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 4'h0, 2'b00, 4'h0, 1'b0, 4'h0);
        #1;
        chk("flush_out_valid", 64'(bus.out_valid), 64'h0);
        chk("flush_in_ready",  64'(bus.in_ready),  64'h1);
        chk("flush_flags",     64'(flags_q),       64'(saved_flags));
        step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 7), $urandom, 4'($urandom), 2'($urandom),
                  4'($urandom), 1'($urandom), 4'($urandom));
            bus.out_ready = 1'($urandom);
            flush = ($urandom_range(0, 19) == 0);
            step();
        end
        flush = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
